// File: rtl/byte_stream_splitter.sv
// byte_stream_splitter: forks one stream of packed operand pairs into two
// independently handshaked byte lanes (a = upper half, b = lower half).
// It marks the last beat of every STREAM_LENGTH-word stream and pulses
// stream_done once both lanes have delivered that beat.
module byte_stream_splitter #(
    parameter  int DATA_WIDTH    = 8,
    parameter  int STREAM_LENGTH = 16,
    localparam int CW            = $clog2(STREAM_LENGTH)
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic [2*DATA_WIDTH-1:0] in_data,
    input  logic                    in_valid,
    output logic                    in_ready,
    output logic [DATA_WIDTH-1:0]   a_data,
    output logic                    a_valid,
    output logic                    a_last,
    input  logic                    a_ready,
    output logic [DATA_WIDTH-1:0]   b_data,
    output logic                    b_valid,
    output logic                    b_last,
    input  logic                    b_ready,
    output logic [CW-1:0]           word_index,
    output logic                    stream_done
);

    logic accept;
    logic a_hs;
    logic b_hs;
    logic index_is_last;
    logic a_done;
    logic b_done;
    logic both_done;
    logic a_last_sent;
    logic b_last_sent;

    // A word is taken only when both lane registers are empty or draining this
    // cycle, so neither lane can be overwritten before it is consumed.
    assign in_ready      = reset && (!a_valid || a_ready) && (!b_valid || b_ready);
    assign accept        = in_valid && in_ready;
    assign a_hs          = a_valid && a_ready;
    assign b_hs          = b_valid && b_ready;
    assign index_is_last = (word_index == CW'(STREAM_LENGTH - 1));

    // A lane counts as done if its last beat went out earlier in the stream
    // or is going out right now; this lets the pulse follow the later
    // handshake by exactly one cycle.
    assign a_done    = a_last_sent || (a_hs && a_last);
    assign b_done    = b_last_sent || (b_hs && b_last);
    assign both_done = a_done && b_done;

    // Lane A output register: load on accept, otherwise clear once consumed.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            // NOTE: sequential state uses non-blocking assignments so every
            // register samples pre-edge values regardless of block order.
            a_data  <= '0;
            a_valid <= 1'b0;
            a_last  <= 1'b0;
        end else if (accept) begin
            a_data  <= in_data[2*DATA_WIDTH-1:DATA_WIDTH];
            a_valid <= 1'b1;
            a_last  <= index_is_last;
        end else if (a_hs) begin
            a_valid <= 1'b0;
        end
    end

    // Lane B output register: same behaviour as lane A on the lower half.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            b_data  <= '0;
            b_valid <= 1'b0;
            b_last  <= 1'b0;
        end else if (accept) begin
            b_data  <= in_data[DATA_WIDTH-1:0];
            b_valid <= 1'b1;
            b_last  <= index_is_last;
        end else if (b_hs) begin
            b_valid <= 1'b0;
        end
    end

    // Word position within the stream, wrapping after the last word.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            word_index <= '0;
        end else if (accept) begin
            if (index_is_last) begin
                word_index <= '0;
            end else begin
                word_index <= word_index + 1'b1;
            end
        end
    end

    // Sticky per-lane last-beat flags; one-cycle done pulse when both are in.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            a_last_sent <= 1'b0;
            b_last_sent <= 1'b0;
            stream_done <= 1'b0;
        end else begin
            stream_done <= both_done;
            a_last_sent <= a_done && !both_done;
            b_last_sent <= b_done && !both_done;
        end
    end

endmodule

// File: tb/tb_byte_stream_splitter.sv
// Self-checking bench for byte_stream_splitter: a model process pushes
// expected beats per lane on each accepted word; a monitor process pops and
// compares on each lane handshake and tracks the expected done pulse.
module tb_byte_stream_splitter;

    localparam int DW = 8;
    localparam int L  = 16;
    localparam int CW = $clog2(L);

    typedef struct {
        logic [DW-1:0] data;
        logic          last;
    } beat_t;

    logic            clock = 1'b0;
    logic            reset;
    logic [2*DW-1:0] in_data;
    logic            in_valid;
    logic            in_ready;
    logic [DW-1:0]   a_data;
    logic            a_valid;
    logic            a_last;
    logic            a_ready;
    logic [DW-1:0]   b_data;
    logic            b_valid;
    logic            b_last;
    logic            b_ready;
    logic [CW-1:0]   word_index;
    logic            stream_done;

    byte_stream_splitter #(.DATA_WIDTH(DW), .STREAM_LENGTH(L)) dut (
        .clock(clock), .reset(reset),
        .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .a_data(a_data), .a_valid(a_valid), .a_last(a_last), .a_ready(a_ready),
        .b_data(b_data), .b_valid(b_valid), .b_last(b_last), .b_ready(b_ready),
        .word_index(word_index), .stream_done(stream_done)
    );

    always #5 clock = ~clock;

    int    tests = 0;
    int    fails = 0;
    beat_t qa[$];
    beat_t qb[$];
    int    accepted   = 0;
    int    done_count = 0;
    int    cycle      = 0;
    bit    rand_rdy   = 0;
    logic  exp_done   = 1'b0;
    bit    a_seen     = 0;
    bit    b_seen     = 0;
    beat_t ea;
    beat_t eb;
    logic  nxt_done;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    always @(posedge clock) cycle++;
    always @(negedge clock) if (stream_done === 1'b1) done_count++;

    // Reference model: word n since reset is stream position n mod L.
    initial forever begin
        @(negedge clock);
        #1;
        if (reset !== 1'b1) begin
            accepted = 0;
        end else begin
            check("word_index", 32'(word_index), accepted % L);
            if (in_valid && in_ready) begin
                qa.push_back('{data: in_data[2*DW-1:DW], last: ((accepted % L) == L - 1)});
                qb.push_back('{data: in_data[DW-1:0],    last: ((accepted % L) == L - 1)});
                accepted++;
            end
        end
    end

    // Monitor: lane occupancy equals the number of pending expected beats.
    initial forever begin
        @(negedge clock);
        if (reset !== 1'b1) begin
            qa.delete();
            qb.delete();
            a_seen   = 0;
            b_seen   = 0;
            exp_done = 1'b0;
            check("rst_a_valid", 32'(a_valid), 0);
            check("rst_b_valid", 32'(b_valid), 0);
            check("rst_in_ready", 32'(in_ready), 0);
            check("rst_stream_done", 32'(stream_done), 0);
        end else begin
            check("stream_done", 32'(stream_done), 32'(exp_done));
            check("in_ready", 32'(in_ready),
                  32'((qa.size() == 0 || a_ready) && (qb.size() == 0 || b_ready)));
            check("a_valid", 32'(a_valid), 32'(qa.size() != 0));
            check("b_valid", 32'(b_valid), 32'(qb.size() != 0));
            nxt_done = 1'b0;
            if (a_valid && a_ready && qa.size() != 0) begin
                ea = qa.pop_front();
                check("a_data", 32'(a_data), 32'(ea.data));
                check("a_last", 32'(a_last), 32'(ea.last));
                if (ea.last) a_seen = 1;
            end
            if (b_valid && b_ready && qb.size() != 0) begin
                eb = qb.pop_front();
                check("b_data", 32'(b_data), 32'(eb.data));
                check("b_last", 32'(b_last), 32'(eb.last));
                if (eb.last) b_seen = 1;
            end
            if (a_seen && b_seen) begin
                nxt_done = 1'b1;
                a_seen   = 0;
                b_seen   = 0;
            end
            exp_done = nxt_done;
        end
    end

    task automatic tick();
        @(posedge clock);
        #1;
        if (rand_rdy) begin
            a_ready = 1'($urandom_range(0, 1));
            b_ready = 1'($urandom_range(0, 1));
        end
    endtask

    task automatic send(input logic [2*DW-1:0] d);
        int   n   = 0;
        logic acc = 1'b0;
        in_data  = d;
        in_valid = 1'b1;
        while (!acc && n < 200) begin
            @(negedge clock);
            acc = in_ready;
            tick();
            n++;
        end
        if (!acc) check("send_timeout", 32'(acc), 1);
        in_valid = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int            d0;
        int            start;
        logic [DW-1:0] av;
        logic [DW-1:0] bv;

        reset    = 1'b0;
        in_valid = 1'b1;
        in_data  = 16'hDEAD;
        a_ready  = 1'b0;
        b_ready  = 1'b0;

        // Reset holds in_ready low even with in_valid asserted.
        repeat (2) @(negedge clock);
        check("hold_in_ready", 32'(in_ready), 0);
        check("hold_a_valid", 32'(a_valid), 0);
        check("hold_b_valid", 32'(b_valid), 0);
        @(posedge clock);
        #1;
        reset = 1'b1;
        @(negedge clock);
        check("release_in_ready", 32'(in_ready), 1);
        in_valid = 1'b0;
        tick();

        // Full-rate stream of {i, 15-i}.
        a_ready = 1'b1;
        b_ready = 1'b1;
        d0      = done_count;
        start   = cycle;
        for (int i = 0; i < 16; i++) begin
            av = i[DW-1:0];
            bv = DW'(15 - i);
            send({av, bv});
        end
        check("throughput_cycles", 32'(cycle - start), 16);
        repeat (3) tick();
        check("throughput_done_pulses", 32'(done_count - d0), 1);
        check("throughput_word_index", 32'(word_index), 0);

        // Skewed stall: lane B blocked for three cycles.
        a_ready = 1'b1;
        b_ready = 1'b0;
        send(16'hAA55);
        in_valid = 1'b1;
        in_data  = 16'h1234;
        for (int k = 0; k < 3; k++) begin
            @(negedge clock);
            check("stall_in_ready", 32'(in_ready), 0);
            check("stall_b_valid", 32'(b_valid), 1);
            check("stall_b_data", 32'(b_data), 32'h55);
            tick();
        end
        b_ready = 1'b1;
        @(negedge clock);
        check("unstall_in_ready", 32'(in_ready), 1);
        tick();
        in_valid = 1'b0;

        // Simultaneous drain and accept with both lanes full.
        a_ready = 1'b0;
        b_ready = 1'b0;
        tick();
        a_ready  = 1'b1;
        b_ready  = 1'b1;
        in_valid = 1'b1;
        in_data  = 16'h9ABC;
        @(negedge clock);
        check("simul_in_ready", 32'(in_ready), 1);
        tick();
        in_valid = 1'b0;
        @(negedge clock);
        check("simul_a_valid", 32'(a_valid), 1);
        check("simul_a_data", 32'(a_data), 32'h9A);
        check("simul_b_valid", 32'(b_valid), 1);
        check("simul_b_data", 32'(b_data), 32'hBC);
        tick();

        // Split last: lane A's last handshake two cycles ahead of lane B's.
        while ((accepted % L) != L - 1) send(16'($urandom));
        send(16'hF00F);
        a_ready = 1'b1;
        b_ready = 1'b0;
        d0      = done_count;
        tick();
        tick();
        b_ready = 1'b1;
        @(negedge clock);
        check("split_done_early", 32'(stream_done), 0);
        tick();
        @(negedge clock);
        check("split_done", 32'(stream_done), 1);
        tick();
        @(negedge clock);
        check("split_done_once", 32'(stream_done), 0);
        tick();
        check("split_done_pulses", 32'(done_count - d0), 1);

        // Reset after five words, then a full stream from index 0.
        for (int i = 0; i < 5; i++) send(16'($urandom));
        reset = 1'b0;
        @(negedge clock);
        check("midrst_a_valid", 32'(a_valid), 0);
        check("midrst_b_valid", 32'(b_valid), 0);
        check("midrst_word_index", 32'(word_index), 0);
        tick();
        reset    = 1'b1;
        d0       = done_count;
        rand_rdy = 1;
        for (int i = 0; i < 16; i++) send(16'($urandom));
        rand_rdy = 0;
        a_ready  = 1'b1;
        b_ready  = 1'b1;
        repeat (4) tick();
        check("midrst_done_pulses", 32'(done_count - d0), 1);

        // Random readies and random input gaps.
        rand_rdy = 1;
        for (int i = 0; i < 60; i++) begin
            send(16'($urandom));
            if ($urandom_range(0, 3) == 0) tick();
        end
        rand_rdy = 0;
        a_ready  = 1'b1;
        b_ready  = 1'b1;
        for (int i = 0; i < 50 && (qa.size() + qb.size()) != 0; i++) tick();
        check("drain_empty", 32'(qa.size() + qb.size()), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/byte_stream_splitter.md
# byte_stream_splitter

Fork-side counterpart of the byte stream adder's two-input join. Accepts one valid/ready stream of packed operand pairs and splits each word into two independent byte streams, `a` and `b`, each with its own valid/ready handshake. Marks the last beat of every STREAM_LENGTH-word stream and pulses a completion flag. It sits upstream of the adder and drives its `a`/`b` inputs from a single source stream.

## Interface
- DATA_WIDTH, 8, width of each output byte lane
- STREAM_LENGTH, 16, words per stream (≥2); sets `last` position and counter wrap
- CW (localparam), $clog2(STREAM_LENGTH), counter width
- clock  in  1  single clock; all state updates on rising edge
- reset  in  1  asynchronous, active-low reset (asserted at 0)
- in_data  in  2*DATA_WIDTH  packed pair; upper half goes to `a`, lower half to `b`
- in_valid  in  1  input word valid
- in_ready  out  1  input word accepted when in_valid && in_ready
- a_data  out  DATA_WIDTH  lane A byte (registered)
- a_valid  out  1  lane A holds an undelivered byte
- a_last  out  1  lane A byte is stream index STREAM_LENGTH-1
- a_ready  in  1  lane A consumer ready
- b_data / b_valid / b_last  out  DATA_WIDTH/1/1  lane B, same meaning as lane A
- b_ready  in  1  lane B consumer ready
- word_index  out  CW  index of the next word to be accepted
- stream_done  out  1  one-cycle pulse after both lanes deliver their last beat

## Operation
- Each lane has a one-entry output register holding data, valid and last.
- in_ready = reset && (!a_valid || a_ready) && (!b_valid || b_ready); combinational, never depends on in_valid.
- On input accept: a_data ← in_data[2*DW-1:DW]; b_data ← in_data[DW-1:0]; a_valid, b_valid ← 1; a_last, b_last ← (word_index == STREAM_LENGTH-1).
- Per lane, a handshake without a same-cycle accept clears that lane's valid. An accept in the same cycle as a handshake reloads the register, and valid stays 1.
- Lanes drain independently. A stalled lane holds data, valid and last stable until it is consumed.
- word_index increments on each accept and wraps from STREAM_LENGTH-1 to 0.
- Done tracking: sticky flags a_last_sent and b_last_sent set on a handshake with last=1.
  - When both flags are set (including when they are set in the same cycle), stream_done is 1 for exactly one cycle on the next edge and both flags clear.
- The next stream's first word may be accepted in the same cycle as the previous stream's final lane handshake.
- No data is dropped or duplicated under any ready pattern.

## Timing
- Reset values: a_valid=b_valid=0, a_last=b_last=0, a_data=b_data=0, word_index=0, stream_done=0, done flags=0.
- in_ready is 0 while reset is asserted and 1 on the first cycle after release.
- Latency: a word accepted at edge N is visible on both lanes after edge N.
- Throughput: one word per cycle with a_ready=b_ready=1 held high, with no bubbles.
- Backpressure on one lane stalls the input but not the other lane's drain.
- Reset mid-stream: valid and pending bytes are discarded immediately (asynchronous), and word_index returns to 0. The next accepted word is index 0.
- stream_done asserts the cycle after the later last-beat handshake.

## Test plan
- Reset: hold in_valid=1 with reset=0 → in_ready=0 and a_valid=b_valid=0. Release reset → in_ready=1 on the next cycle.
- Throughput: 16 words {i, 15-i} with both readies at 1 → a_data=i and b_data=15-i on consecutive cycles. a_last=b_last=1 only for i=15. stream_done pulses once, one cycle after that beat. word_index returns to 0.
- Skewed stall: word {8'hAA, 8'h55} with a_ready=1 and b_ready=0 for 3 cycles → lane A delivers 8'hAA once. b_valid stays 1 with b_data=8'h55. in_ready=0 for all 3 cycles. Raise b_ready → 8'h55 is delivered and in_ready=1.
- Simultaneous drain and accept: with both lanes full, raise a_ready, b_ready and in_valid in the same cycle → the new word is loaded on that edge with valid held at 1, and no bubble appears.
- Split last: lane A's last handshake is 2 cycles before lane B's → stream_done pulses exactly once, one cycle after lane B's handshake.
- Mid-stream reset after 5 accepted words → all valids drop to 0 and word_index=0. The 16th word after release carries last=1.
